// File: rtl/register_file_param.sv
// register_file_param: parametrised register file with a hard-wired zero
// register and a post-reset clear sequencer.
//
// Optional feature macro: REGFILE_WRITE_BYPASS_EN
//   defined   -> a read port that addresses the register being written in the
//                same cycle returns WD3 combinationally (write-first).
//   undefined -> that port returns the stored value until the edge (read-first).
//
// Handshake: there is no valid/ready pair. WE qualifies AD3/WD3 at the rising
// edge. Busy=1 means the clear sequence owns the array: writes are dropped
// and every read port returns zero. Busy falls after the edge that clears the
// last entry.
//
// Debug visibility: the FSM has two states, and Busy is the registered
// decode of (state == CLEAR), so Busy exposes the full FSM state.
module register_file_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  input  logic [NREAD*AW-1:0]   AD,
  input  logic                  WE,
  input  logic [AW-1:0]         AD3,
  input  logic [XLEN-1:0]       WD3,
  output logic [NREAD*XLEN-1:0] RD,
  output logic                  Busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic [AW-1:0] PTR_FIRST = AW'(1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

  state_e            state_q;
  logic   [AW-1:0]   ptr_q;
  logic              busy_q;

  // Entry 0 is not stored; it always reads as zero.
  logic   [XLEN-1:0] mem_q [1:NREGS-1];

  logic              wr_ok;

  // An address is architectural when it is below NREGS (NREGS need not be a
  // power of two, so some encodings of AW bits are unused).
  function automatic logic in_range(input logic [AW-1:0] a);
    return {{(32-AW){1'b0}}, a} < 32'(NREGS);
  endfunction

  // A write lands only in RUN, to a non-zero architectural register.
  assign wr_ok = WE && (AD3 != '0) && in_range(AD3) && (state_q == RUN);

  // Clear sequencer: walk ptr from 1 to NREGS-1, then hand over to RUN.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q <= CLEAR;
      ptr_q   <= PTR_FIRST;
      busy_q  <= 1'b1;
    end else if (state_q == CLEAR) begin
      ptr_q <= ptr_q + AW'(1);
      if (ptr_q == PTR_LAST) begin
        state_q <= RUN;
        busy_q  <= 1'b0;
      end
    end
  end

  // Array update: zero one entry per clear cycle, otherwise take the write
  // port. The reset cycle leaves contents untouched.
  always_ff @(posedge clk) begin
    if (Reset_n) begin
      if (state_q == CLEAR) begin
        mem_q[ptr_q] <= '0;
      end else if (wr_ok) begin
        mem_q[AD3] <= WD3;
      end
    end
  end

  // Combinational read ports, each independent; zero while clearing or for
  // x0 / out-of-range addresses.
  always_comb begin
    RD = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (!busy_q && (AD[k*AW +: AW] != '0) && in_range(AD[k*AW +: AW])) begin
        RD[k*XLEN +: XLEN] = mem_q[AD[k*AW +: AW]];
      end
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_ok && (AD[k*AW +: AW] == AD3)) begin
        RD[k*XLEN +: XLEN] = WD3;
      end
`endif
    end
  end

  assign Busy = busy_q;

endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: directed bench for register_file_param.
// Two instances share stimulus: the default build (NREGS=32) and a
// non-power-of-two build (NREGS=24); both have 5-bit addresses.
module tb_register_file_param;

  localparam int AWB = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              Reset_n;
  logic [2*AWB-1:0]  AD;
  logic              WE;
  logic [AWB-1:0]    AD3;
  logic [31:0]       WD3;
  logic [63:0]       rd32, rd24;
  logic              busy32, busy24;

  register_file_param #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk(clk), .Reset_n(Reset_n), .AD(AD), .WE(WE), .AD3(AD3), .WD3(WD3),
    .RD(rd32), .Busy(busy32)
  );

  register_file_param #(.XLEN(32), .NREGS(24), .NREAD(2)) dut24 (
    .clk(clk), .Reset_n(Reset_n), .AD(AD), .WE(WE), .AD3(AD3), .WD3(WD3),
    .RD(rd24), .Busy(busy24)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: register contents, busy flag, number of entries cleared.
  int          nregs [2] = '{32, 24};
  logic [31:0] mdl   [2][32];
  logic        mbusy [2];
  int          mcnt  [2];
  logic        mdl_on = 1'b0;

  always @(posedge clk) begin
    if (!Reset_n) mdl_on <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (!Reset_n) begin
        mbusy[i] <= 1'b1;
        mcnt[i]  <= 0;
      end else if (mdl_on) begin
        if (mbusy[i]) begin
          mdl[i][mcnt[i] + 1] <= '0;
          mcnt[i] <= mcnt[i] + 1;
          if (mcnt[i] + 1 == nregs[i] - 1) mbusy[i] <= 1'b0;
        end else if (WE && AD3 != 0 && int'(AD3) < nregs[i]) begin
          mdl[i][AD3] <= WD3;
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd(input int inst, input int port);
    int a;
    a = int'(AD[port*AWB +: AWB]);
    if (mbusy[inst] || a == 0 || a >= nregs[inst]) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (WE && int'(AD3) == a) return WD3;
`endif
    return mdl[inst][a];
  endfunction

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (mdl_on) begin
      check("busy32", 32'(busy32), 32'(mbusy[0]));
      check("busy24", 32'(busy24), 32'(mbusy[1]));
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rd32_p%0d", k), rd32[k*32 +: 32], exp_rd(0, k));
        check($sformatf("rd24_p%0d", k), rd24[k*32 +: 32], exp_rd(1, k));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ad(input int a0, input int a1);
    AD = {AWB'(a1), AWB'(a0)};
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    WE = 1'b1; AD3 = AWB'(a); WD3 = d;
    wait_edge();
    WE = 1'b0;
  endtask

  // Count edges (with Reset_n=1) until Busy falls; returns 0 if it never does.
  task automatic clear_latency(input int max_edges, output int lat32, output int lat24);
    lat32 = 0; lat24 = 0;
    for (int e = 1; e <= max_edges; e++) begin
      wait_edge();
      if (lat32 == 0 && busy32 === 1'b0) lat32 = e;
      if (lat24 == 0 && busy24 === 1'b0) lat24 = e;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat32, lat24;
    Reset_n = 1'b0; WE = 1'b0; AD3 = '0; WD3 = '0; AD = '0;

    // Reset held for two edges.
    wait_edge();
    check("reset_busy", 32'(busy32), 32'h1);
    check("reset_rd", rd32[31:0], 32'h0);
    wait_edge();

    // Release and clear; a write offered on the 5th clear edge is dropped.
    Reset_n = 1'b1;
    set_ad(5, 3);
    lat32 = 0; lat24 = 0;
    for (int e = 1; e <= 40; e++) begin
      WE = (e == 5); AD3 = 5'd3; WD3 = 32'hAAAA_AAAA;
      wait_edge();
      if (lat32 == 0 && busy32 === 1'b0) lat32 = e;
      if (lat24 == 0 && busy24 === 1'b0) lat24 = e;
    end
    WE = 1'b0;
    check("clear_lat32", 32'(lat32), 32'd31);
    check("clear_lat24", 32'(lat24), 32'd23);
    #1;
    check("x5_after_clear", rd32[31:0], 32'h0);
    check("x3_write_in_clear", rd32[63:32], 32'h0);

    // Basic write/read.
    do_write(1, 32'h0000_0001);
    do_write(2, 32'h0000_0002);
    set_ad(1, 2);
    #1;
    check("basic_rd0", rd32[31:0], 32'h1);
    check("basic_rd1", rd32[63:32], 32'h2);

    // x0 write ignored.
    do_write(0, 32'hDEAD_BEEF);
    set_ad(0, 1);
    #1;
    check("x0_read", rd32[31:0], 32'h0);

    // Address 30: valid for NREGS=32, out of range for NREGS=24.
    do_write(30, 32'h0000_1234);
    set_ad(30, 30);
    #1;
    check("oor24_read", rd24[31:0], 32'h0);
    check("r30_32_read", rd32[31:0], 32'h0000_1234);

    // Bypass / read-first behaviour on x7.
    do_write(7, 32'h11);
    WE = 1'b1; AD3 = 5'd7; WD3 = 32'h22; set_ad(7, 1);
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("same_cycle_rw", rd32[31:0], 32'h22);
`else
    check("same_cycle_rw", rd32[31:0], 32'h11);
`endif
    wait_edge();
    WE = 1'b0;
    set_ad(7, 7);
    #1;
    check("after_edge_p0", rd32[31:0], 32'h22);
    check("after_edge_p1", rd32[63:32], 32'h22);

    // Reset while running: back to CLEAR, reads forced to zero.
    Reset_n = 1'b0;
    wait_edge();
    check("run_reset_busy", 32'(busy32), 32'h1);
    check("run_reset_rd", rd32[31:0], 32'h0);

    // Mid-clear reset on clear edge 10, then a full restart.
    Reset_n = 1'b1;
    for (int e = 1; e <= 9; e++) wait_edge();
    Reset_n = 1'b0;
    wait_edge();
    Reset_n = 1'b1;
    clear_latency(40, lat32, lat24);
    check("restart_lat32", 32'(lat32), 32'd31);
    check("restart_lat24", 32'(lat24), 32'd23);
    set_ad(7, 30);
    #1;
    check("x7_recleared", rd32[31:0], 32'h0);

    // Fill every address, reading back pairs as we go.
    for (int i = 0; i < 32; i++) begin
      set_ad(i, 31 - i);
      do_write(i, 32'h1000_0000 + 32'(i));
    end
    set_ad(24, 23);
    #1;
    check("fill_r24_32", rd32[31:0], 32'h1000_0018);
    check("fill_r24_24", rd24[31:0], 32'h0);
    check("fill_r23_24", rd24[63:32], 32'h1000_0017);
    wait_edge();
    wait_edge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
# register_file_param

Parametrised successor to the single-cycle core's 32x32 register file, with configurable data width, register count and number of combinational read ports. Register 0 is hard-wired to zero. A post-reset clear sequencer zeroes the array one entry per cycle and reports progress on `Busy`, so no large reset fan-out is needed. It sits between the decode stage (read addresses) and the write-back mux (write port) of the single-cycle datapath.

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of architectural registers; 2..64, need not be a power of two
- `NREAD`, 2, number of read ports; 1..4
- `AW` (localparam), `$clog2(NREGS)`, address width

- `clk` input 1: single clock; all state changes on the rising edge
- `Reset_n` input 1: reset, synchronous, active-low
- `AD` input `NREAD*AW`: read addresses, packed; port k = `AD[k*AW +: AW]`
- `WE` input 1: write enable
- `AD3` input `AW`: write address
- `WD3` input `XLEN`: write data
- `RD` output `NREAD*XLEN`: read data, packed; port k = `RD[k*XLEN +: XLEN]`
- `Busy` output 1: clear sequence in progress

## Operation
- Storage: `NREGS-1` entries of `XLEN` bits (index 1..NREGS-1). Index 0 is not stored and always reads as 0.
- FSM states are `CLEAR` and `RUN`, with a pointer `ptr` (`AW` bits).
- Reset (`Reset_n`=0 at a rising edge):
  - state ← `CLEAR`, `ptr` ← 1.
  - Array contents are not touched in the reset cycle.
- `CLEAR`, `Reset_n`=1:
  - each edge writes `mem[ptr]` ← 0 and increments `ptr`.
  - On the edge that clears `NREGS-1`, state ← `RUN`.
- `RUN`, write: an edge with `WE`=1, `AD3`≠0 and `AD3`<`NREGS` stores `WD3` in `mem[AD3]`.
- Ignored writes: `AD3`=0 or `AD3`≥`NREGS`.
- Reads (combinational, every port independently):
  - `RD`k = 0 if `AD`k=0, `AD`k≥`NREGS`, or `Busy`=1; otherwise `mem[AD`k`]`.
  - Several ports may address the same register.
- `Busy` = (state == `CLEAR`), a registered output.
- Writes during `CLEAR` are dropped; no queueing.

## Timing
- Reset values: `Busy`=1 from the first edge with `Reset_n`=0; `RD` = all zeros while `Busy`=1.
- Clear latency: `NREGS-1` edges after the first edge with `Reset_n`=1.
  - `Busy` falls after the edge that clears the last entry.
  - Default: 31 cycles.
- Reset asserted mid-clear: the sequence restarts from `ptr`=1. Entries already cleared stay 0.
- Reset asserted in `RUN`: re-enters `CLEAR`. Contents are still readable as 0 because `Busy`=1.
- Write latency: data written at edge N is visible on `RD` right after edge N (no bypass build).
- Read latency: 0 cycles, combinational from `AD`.
- Simultaneous read and write of the same register in one cycle: see Configuration.

## Configuration
- Macro `REGFILE_WRITE_BYPASS_EN`.
- Defined:
  - in `RUN`, any read port with `AD`k == `AD3`, `WE`=1, `AD3`≠0 and `AD3`<`NREGS` returns `WD3` combinationally in the same cycle (write-first).
  - Lets the register file serve a pipelined successor core.
- Undefined: that port returns the old stored value until the edge (read-first).
- Storage, clear FSM and `Busy` behaviour are identical in both builds.

## Test plan
- Reset then clear:
  - hold `Reset_n`=0 for 2 edges, then release.
  - `Busy`=1 for exactly 31 edges, then 0.
  - All `RD` = 0 throughout.
  - Reading x5 after `Busy` falls returns 0.
- Basic write/read (defaults):
  - write `AD3`=1, `WD3`=32'h0000_0001; next cycle write `AD3`=2, `WD3`=32'h0000_0002.
  - Then `AD`0=1, `AD`1=2 gives `RD`0=1, `RD`1=2.
- x0 and out-of-range:
  - write `AD3`=0, `WD3`=32'hDEAD_BEEF; then read port 0 at address 0 → 0.
  - With `NREGS`=24, write `AD3`=30, `WD3`=32'h1234; then read address 30 → 0.
- Write during clear:
  - `WE`=1, `AD3`=3, `WD3`=32'hAAAA_AAAA on the 5th clear edge.
  - After `Busy`=0, reading 3 → 0.
- Mid-clear reset:
  - assert `Reset_n`=0 at clear edge 10, release.
  - `Busy` stays 1 for a further 31 edges.
- Bypass:
  - stored x7 = 32'h11; same cycle `WE`=1, `AD3`=7, `WD3`=32'h22, `AD`0=7.
  - With `REGFILE_WRITE_BYPASS_EN`, `RD`0=32'h22 before the edge.
  - Without the macro, `RD`0=32'h11 before the edge and 32'h22 after.
